ring_stream: RTL

Parametrised circular playback buffer for the frequency selector: tones are loaded one word per write into an internal block RAM, then replayed endlessly in address order as a valid/ready stream. Every output word carries its source address. An independent pipelined random-read port shares the RAM read port. It generalises the fixed 14-bit/128-entry ring with the following changes:

- configurable width, depth and prefetch depth;
- a true handshake with a stored index;
- a clear input;
- an overflow flag.

---
 rtl/ring_stream.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/ring_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ring_stream                                                |
// | Description : Circular playback buffer. Words are appended one per write |
// |               into a simple dual-port RAM and replayed endlessly in      |
// |               address order as a valid/ready stream tagged with its RAM  |
// |               address. A pipelined random-read port shares the RAM read  |
// |               port with the prefetcher.                                  |
// |               Optional: define RING_WRAP_CNT_EN to enable the completed- |
// |               pass counter on wrap_cnt (tied to 0 otherwise).            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ring_stream #(
  parameter int DATA_W   = 14,
  parameter int ADDR_W   = 7,
  parameter int PF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              clr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              ovf,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] dout_index,
  output logic              dout_valid,
  input  logic              dout_ready,
  input  logic [ADDR_W-1:0] rand_addr,
  input  logic              rand_req,
  output logic [DATA_W-1:0] rand_dout,
  output logic              rand_valid,
  output logic [15:0]       wrap_cnt
);

  localparam int c_DEPTH = 1 << ADDR_W;
  localparam int c_PTR_W = $clog2(PF_DEPTH);
  localparam int c_LVL_W = $clog2(PF_DEPTH + 1) + 1;
  localparam logic [ADDR_W:0]    c_FULL_CNT = (ADDR_W + 1)'(c_DEPTH);
  localparam logic [c_LVL_W-1:0] c_PF_LVL   = c_LVL_W'(PF_DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(PF_DEPTH - 1);

  // Storage and state
  logic [DATA_W-1:0]  r_mem [c_DEPTH];
  logic [ADDR_W:0]    r_count;
  logic               r_ovf;
  logic [ADDR_W-1:0]  r_rp;
  logic [DATA_W-1:0]  r_ram_q;
  logic               r_ret_vld;
  logic [ADDR_W-1:0]  r_ret_idx;
  logic [DATA_W-1:0]  r_fifo_data [PF_DEPTH];
  logic [ADDR_W-1:0]  r_fifo_idx  [PF_DEPTH];
  logic [c_PTR_W-1:0] r_fifo_rd;
  logic [c_PTR_W-1:0] r_fifo_wr;
  logic [c_LVL_W-1:0] r_fifo_occ;
  logic               r_rand_pend;
  logic               r_rand_oob;
  logic [DATA_W-1:0]  r_rand_dout;
  logic               r_rand_valid;

  // Combinational control
  logic               w_full;
  logic               w_wr_acc;
  logic               w_flush;
  logic               w_fifo_nempty;
  logic               w_head_vld;
  logic [ADDR_W-1:0]  w_head_idx;
  logic               w_pop;
  logic               w_fifo_pop;
  logic               w_push;
  logic [c_LVL_W-1:0] w_level;
  logic               w_issue;
  logic               w_rd_en;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [ADDR_W:0]    w_cnt_m1;
  logic               w_rp_last;
  logic               w_rand_oob;

  function automatic logic [c_PTR_W-1:0] f_ptr_next(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_full        = (r_count == c_FULL_CNT);
  assign w_wr_acc      = wr_en & ~w_full & ~clr;
  assign w_flush       = w_wr_acc | clr;
  assign w_cnt_m1      = r_count - 1'b1;
  assign w_rp_last     = ({1'b0, r_rp} == w_cnt_m1);
  assign w_rand_oob    = ({1'b0, rand_addr} >= r_count);

  // The FIFO head is the oldest stored word; when the FIFO is empty the word
  // just returned by the RAM is presented directly so a fresh stream starts
  // two cycles after the triggering write.
  assign w_fifo_nempty = (r_fifo_occ != '0);
  assign w_head_vld    = w_fifo_nempty | r_ret_vld;
  assign w_head_idx    = w_fifo_nempty ? r_fifo_idx[r_fifo_rd] : r_ret_idx;
  assign w_pop         = w_head_vld & dout_ready;
  assign w_fifo_pop    = w_pop & w_fifo_nempty;
  // A return is stored unless it is consumed straight away or a flush kills it.
  assign w_push        = r_ret_vld & ~(w_pop & ~w_fifo_nempty) & ~w_flush;

  // Words held or returning, after this cycle's pop; a new issue must fit.
  assign w_level       = r_fifo_occ + c_LVL_W'(r_ret_vld) - c_LVL_W'(w_pop);
  assign w_issue       = (r_count != '0) & ~w_flush & ~rand_req & (w_level < c_PF_LVL);
  assign w_rd_en       = w_issue | rand_req;
  assign w_rd_addr     = rand_req ? rand_addr : r_rp;

  // RAM write port: append at the current fill level.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_count[ADDR_W-1:0]] <= din;
    end
  end

  // RAM read port with output register; non-blocking read gives read-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_q <= '0;
    end else if (w_rd_en) begin
      r_ram_q <= r_mem[w_rd_addr];
    end
  end

  // Fill level and sticky overflow; clear outranks a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (wr_en) begin
      if (w_full) begin
        r_ovf <= 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Prefetch read pointer, wrapping at the fill level.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_rp <= '0;
    end else if (w_issue) begin
      r_rp <= w_rp_last ? '0 : r_rp + 1'b1;
    end
  end

  // Return tag for the prefetch read. Reads are one cycle deep and none
  // issue during a flush, so no pre-flush read survives the flush edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ret_vld <= 1'b0;
      r_ret_idx <= '0;
    end else begin
      r_ret_vld <= w_issue;
      if (w_issue) begin
        r_ret_idx <= r_rp;
      end
    end
  end

  // Prefetch FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_fifo_wr] <= r_ram_q;
      r_fifo_idx[r_fifo_wr]  <= r_ret_idx;
    end
  end

  // Prefetch FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_fifo_rd  <= '0;
      r_fifo_wr  <= '0;
      r_fifo_occ <= '0;
    end else begin
      if (w_push) begin
        r_fifo_wr <= f_ptr_next(r_fifo_wr);
      end
      if (w_fifo_pop) begin
        r_fifo_rd <= f_ptr_next(r_fifo_rd);
      end
      r_fifo_occ <= r_fifo_occ + c_LVL_W'(w_push) - c_LVL_W'(w_fifo_pop);
    end
  end

  // Random-read pipeline: RAM stage then output register; a flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rand_pend  <= 1'b0;
      r_rand_oob   <= 1'b0;
      r_rand_valid <= 1'b0;
      r_rand_dout  <= '0;
    end else begin
      r_rand_pend  <= rand_req;
      r_rand_oob   <= w_rand_oob;
      r_rand_valid <= r_rand_pend;
      if (r_rand_pend) begin
        r_rand_dout <= r_rand_oob ? '0 : r_ram_q;
      end
    end
  end

`ifdef RING_WRAP_CNT_EN
  logic [15:0] r_wrap_cnt;

  // Count transfers of the last stored word, saturating.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_wrap_cnt <= '0;
    end else if (w_pop && ({1'b0, w_head_idx} == w_cnt_m1) && (r_wrap_cnt != 16'hFFFF)) begin
      r_wrap_cnt <= r_wrap_cnt + 16'd1;
    end
  end

  assign wrap_cnt = r_wrap_cnt;
`else
  assign wrap_cnt = '0;
`endif

  assign count      = r_count;
  assign full       = w_full;
  assign ovf        = r_ovf;
  assign dout       = w_fifo_nempty ? r_fifo_data[r_fifo_rd] : r_ram_q;
  assign dout_index = w_head_idx;
  assign dout_valid = w_head_vld;
  assign rand_dout  = r_rand_dout;
  assign rand_valid = r_rand_valid;

endmodule
`default_nettype wire
